xmit_prio_scheduler: RTL and testbench

Frame-level scheduler between the high- and low-priority transmit queues and the PHY serializer in the xmit path. It picks the next frame (strict priority plus a low-priority anti-starvation limit) and validates its 24-bit control word. It then either streams the frame's bytes to the serializer or drains and discards them, and enforces an inter-frame gap. Runs entirely on clk_sys.

---
 rtl/xmit_prio_scheduler_if.sv | 20 ++
 rtl/xmit_prio_scheduler.sv | 94 +++++++++
 tb/tb_xmit_prio_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xmit_prio_scheduler_if.sv
// xmit_prio_scheduler_if: queue, serializer and status signals of the transmit scheduler
interface xmit_prio_scheduler_if;
    logic        hi_frame_avail, lo_frame_avail;
    logic [23:0] hi_ctrl, lo_ctrl;
    logic [7:0]  hi_data, lo_data;
    logic        hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd;
    logic        tx_ready, tx_done;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_sof, tx_eof, tx_hi, discard_en, busy;
    modport master (
        output hi_frame_avail, lo_frame_avail, hi_ctrl, lo_ctrl, hi_data, lo_data, tx_ready, tx_done,
        input  hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, tx_data, tx_valid, tx_sof, tx_eof,
               tx_hi, discard_en, busy
    );
    modport slave (
        input  hi_frame_avail, lo_frame_avail, hi_ctrl, lo_ctrl, hi_data, lo_data, tx_ready, tx_done,
        output hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, tx_data, tx_valid, tx_sof, tx_eof,
               tx_hi, discard_en, busy
    );
endinterface

// File: rtl/xmit_prio_scheduler.sv
// xmit_prio_scheduler: strict-priority frame scheduler with lo anti-starvation, length check and inter-frame gap
module xmit_prio_scheduler #(
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter int HI_BURST   = 4,
    parameter int IFG_CYCLES = 12
) (
    input logic clk_sys,
    input logic reset,
    xmit_prio_scheduler_if.slave bus
);
    localparam int SW = $clog2(HI_BURST + 1);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, GAP, DISCARD} state_t;
    state_t state, state_n;
    logic [11:0] len, len_n, cnt, cnt_n, grant_len;
    logic [SW-1:0] hi_streak, hi_streak_n;
    logic [15:0] gap_cnt, gap_cnt_n;
    logic sel_hi, sel_hi_n;
    logic lo_grant, hi_grant, rd, send_rd, last_rd, gap_last;
    logic tx_valid_q, tx_sof_q, tx_eof_q;
    logic unused_tags;
    assign unused_tags = ^{bus.hi_ctrl[23:12], bus.lo_ctrl[23:12]};
    always_comb begin
        lo_grant = state == IDLE && !reset && bus.lo_frame_avail &&
                   (!bus.hi_frame_avail || int'(hi_streak) == HI_BURST);
        hi_grant = state == IDLE && !reset && bus.hi_frame_avail && !lo_grant;
        grant_len = lo_grant ? bus.lo_ctrl[11:0] : bus.hi_ctrl[11:0];
        rd = !reset && ((state == SEND && bus.tx_ready) || (state == DISCARD && cnt != len));
        send_rd = state == SEND && rd;
        last_rd = cnt + 12'd1 >= len;
        gap_last = int'(gap_cnt) + 1 >= IFG_CYCLES;
        state_n = state;
        len_n = len;
        cnt_n = cnt;
        hi_streak_n = hi_streak;
        gap_cnt_n = gap_cnt;
        sel_hi_n = sel_hi;
        if (lo_grant || hi_grant) begin
            len_n = grant_len;
            cnt_n = '0;
            sel_hi_n = hi_grant;
            hi_streak_n = !(hi_grant && bus.lo_frame_avail) ? '0 :
                          int'(hi_streak) == HI_BURST ? hi_streak : hi_streak + SW'(1);
            state_n = (grant_len >= 12'(MIN_LEN) && grant_len <= 12'(MAX_LEN)) ? SEND : DISCARD;
        end else if (send_rd) begin
            cnt_n = cnt + 12'd1;
            state_n = last_rd ? WAIT_DONE : SEND;
        end else if (state == DISCARD) begin
            cnt_n = rd ? cnt + 12'd1 : cnt;
            state_n = last_rd ? IDLE : DISCARD;
        end else if (state == WAIT_DONE && bus.tx_done) begin
            state_n = GAP;
            gap_cnt_n = '0;
        end else if (state == GAP) begin
            gap_cnt_n = gap_cnt + 16'd1;
            state_n = gap_last ? IDLE : GAP;
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            len <= '0;
            cnt <= '0;
            hi_streak <= '0;
            gap_cnt <= '0;
            sel_hi <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_sof_q <= 1'b0;
            tx_eof_q <= 1'b0;
        end else begin
            state <= state_n;
            len <= len_n;
            cnt <= cnt_n;
            hi_streak <= hi_streak_n;
            gap_cnt <= gap_cnt_n;
            sel_hi <= sel_hi_n;
            tx_valid_q <= send_rd;
            tx_sof_q <= send_rd && cnt == '0;
            tx_eof_q <= send_rd && last_rd;
        end
    end
    // data FIFOs present the byte one cycle after the read, exactly when tx_valid rises
    assign bus.tx_data = tx_valid_q ? (sel_hi ? bus.hi_data : bus.lo_data) : '0;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_sof = tx_sof_q;
    assign bus.tx_eof = tx_eof_q;
    assign bus.tx_hi = sel_hi;
    assign bus.hi_ctrl_rd = hi_grant;
    assign bus.lo_ctrl_rd = lo_grant;
    assign bus.hi_data_rd = rd && sel_hi;
    assign bus.lo_data_rd = rd && !sel_hi;
    assign bus.discard_en = state == DISCARD;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_xmit_prio_scheduler.sv
// tb_xmit_prio_scheduler: directed scoreboard bench for the transmit priority scheduler
module tb_xmit_prio_scheduler;
    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    xmit_prio_scheduler_if b ();
    xmit_prio_scheduler dut (.clk_sys(clk_sys), .reset(reset), .bus(b.slave));
    always #5 clk_sys = ~clk_sys;

    int checks = 0, errors = 0;
    logic [23:0] hq[$], lq[$];
    logic [7:0] hd[$], ld[$];
    bit exp_grant[$];
    logic [10:0] exp_byte[$];
    int cyc = 0, n_tx, n_sof, n_eof, n_hrd, n_lrd, n_disc, n_ctrl, n_busy, first_rd, last_rd;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] outs();
        return {b.hi_ctrl_rd, b.lo_ctrl_rd, b.hi_data_rd, b.lo_data_rd, b.tx_data, b.tx_valid,
                b.tx_sof, b.tx_eof, b.tx_hi, b.discard_en, b.busy};
    endfunction

    task automatic clear_counts();
        n_tx = 0; n_sof = 0; n_eof = 0; n_hrd = 0; n_lrd = 0;
        n_disc = 0; n_ctrl = 0; n_busy = 0; first_rd = 0; last_rd = 0;
    endtask

    task automatic load_frame(bit hi, logic [23:0] ctrl, logic [7:0] seed);
        if (hi) hq.push_back(ctrl); else lq.push_back(ctrl);
        for (int i = 0; i < int'(ctrl[11:0]); i++)
            if (hi) hd.push_back(seed + 8'(i)); else ld.push_back(seed + 8'(i));
    endtask

    task automatic expect_frame(bit hi, int len, logic [7:0] seed, bit sent);
        exp_grant.push_back(hi);
        if (sent)
            for (int i = 0; i < len; i++) exp_byte.push_back({hi, i == 0, i == len - 1, seed + 8'(i)});
    endtask

    task automatic wait_drain(string name, int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (!b.busy && hq.size() == 0 && lq.size() == 0 && exp_byte.size() == 0 && exp_grant.size() == 0)
                break;
        end
        chk(name, i < limit, 1);
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    // upstream FIFOs: show-ahead ctrl, data one cycle after read; sole driver of queue-side inputs
    initial begin
        bit hc, lc, hr, lr;
        b.hi_data = '0; b.lo_data = '0;
        b.hi_frame_avail = 1'b0; b.lo_frame_avail = 1'b0; b.hi_ctrl = '0; b.lo_ctrl = '0;
        forever begin
            @(negedge clk_sys);
            hc = b.hi_ctrl_rd; lc = b.lo_ctrl_rd; hr = b.hi_data_rd; lr = b.lo_data_rd;
            @(posedge clk_sys);
            #1;
            if (hc && hq.size() != 0) void'(hq.pop_front());
            if (lc && lq.size() != 0) void'(lq.pop_front());
            if (hr) begin
                chk("hi_data_underflow", hd.size() != 0, 1);
                if (hd.size() != 0) b.hi_data = hd.pop_front();
            end
            if (lr) begin
                chk("lo_data_underflow", ld.size() != 0, 1);
                if (ld.size() != 0) b.lo_data = ld.pop_front();
            end
            b.hi_frame_avail = hq.size() != 0;
            b.lo_frame_avail = lq.size() != 0;
            b.hi_ctrl = hq.size() != 0 ? hq[0] : '0;
            b.lo_ctrl = lq.size() != 0 ? lq[0] : '0;
        end
    end

    // serializer: tx_done pulse three cycles after the last byte
    initial begin
        b.tx_done = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (b.tx_valid && b.tx_eof) begin
                repeat (3) @(posedge clk_sys);
                #1 b.tx_done = 1'b1;
                @(posedge clk_sys);
                #1 b.tx_done = 1'b0;
            end
        end
    end

    initial begin
        bit g;
        logic [10:0] e;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (b.busy) n_busy++;
            if (b.discard_en) n_disc++;
            if (b.hi_ctrl_rd || b.lo_ctrl_rd) begin
                n_ctrl++;
                if (exp_grant.size() == 0) chk("grant_unexpected", {b.hi_ctrl_rd, b.lo_ctrl_rd}, 0);
                else begin
                    g = exp_grant.pop_front();
                    chk("grant", {b.hi_ctrl_rd, b.lo_ctrl_rd}, {g, !g});
                end
            end
            if (b.hi_data_rd || b.lo_data_rd) begin
                if (n_hrd + n_lrd == 0) first_rd = cyc;
                last_rd = cyc;
                n_hrd += int'(b.hi_data_rd);
                n_lrd += int'(b.lo_data_rd);
                chk("data_rd_excl", b.hi_data_rd & b.lo_data_rd, 0);
                if (!b.discard_en) chk("rd_while_stalled", b.tx_ready, 1);
            end
            if (b.tx_valid) begin
                n_tx++;
                n_sof += int'(b.tx_sof);
                n_eof += int'(b.tx_eof);
                chk("tx_during_discard", b.discard_en, 0);
                if (exp_byte.size() == 0) chk("tx_unexpected", b.tx_valid, 0);
                else begin
                    e = exp_byte.pop_front();
                    chk("tx_byte", {b.tx_hi, b.tx_sof, b.tx_eof, b.tx_data}, e);
                end
            end
        end
    end

    initial begin
        int gap;
        b.tx_ready = 1'b1;
        clear_counts();
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        chk("reset_outputs", outs(), 0);

        // single 512-byte hi frame, then the inter-frame gap
        @(posedge clk_sys);
        #1 clear_counts();
        load_frame(1, 24'h200200, 8'h00);
        expect_frame(1, 512, 8'h00, 1);
        for (int i = 0; i < 2000 && b.tx_done !== 1'b1; i++) @(posedge clk_sys);
        chk("t1_done_seen", b.tx_done, 1);
        gap = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sys);
            if (!b.busy) break;
            gap++;
        end
        chk("t1_gap_busy", gap, 12);
        chk("t1_hi_reads", n_hrd, 512);
        chk("t1_lo_reads", n_lrd, 0);
        chk("t1_tx_bytes", n_tx, 512);
        chk("t1_sof", n_sof, 1);
        chk("t1_eof", n_eof, 1);
        chk("t1_tx_hi", b.tx_hi, 1);
        wait_drain("t1_drain", 200);

        // 8 hi + 4 lo frames: expected order H,H,H,H,L,H,H,H,H,L,L,L
        clear_counts();
        for (int k = 0; k < 8; k++) load_frame(1, {12'h0A5, 12'd64}, 8'h10 + 8'(k * 16));
        for (int k = 0; k < 4; k++) load_frame(0, {12'h05A, 12'd64}, 8'h80 + 8'(k * 16));
        for (int k = 0; k < 4; k++) expect_frame(1, 64, 8'h10 + 8'(k * 16), 1);
        expect_frame(0, 64, 8'h80, 1);
        for (int k = 4; k < 8; k++) expect_frame(1, 64, 8'h10 + 8'(k * 16), 1);
        for (int k = 1; k < 4; k++) expect_frame(0, 64, 8'h80 + 8'(k * 16), 1);
        wait_drain("t2_drain", 3000);
        chk("t2_grants", n_ctrl, 12);
        chk("t2_tx_bytes", n_tx, 768);

        // short lo frame is drained without transmission
        clear_counts();
        load_frame(0, {12'h0A5, 12'd20}, 8'h40);
        expect_frame(0, 20, 8'h40, 0);
        wait_drain("t3_drain", 200);
        chk("t3_discard_cycles", n_disc, 20);
        chk("t3_lo_reads", n_lrd, 20);
        chk("t3_tx_bytes", n_tx, 0);
        chk("t3_busy_cycles", n_busy, 20);
        chk("t3_ctrl_pops", n_ctrl, 1);

        // tx_ready toggling every cycle
        clear_counts();
        load_frame(1, {12'h0A5, 12'd100}, 8'h60);
        expect_frame(1, 100, 8'h60, 1);
        for (int i = 0; i < 600 && n_hrd < 100; i++) begin
            @(posedge clk_sys);
            #1 b.tx_ready = ~b.tx_ready;
        end
        b.tx_ready = 1'b1;
        wait_drain("t4_drain", 300);
        chk("t4_hi_reads", n_hrd, 100);
        chk("t4_eof", n_eof, 1);
        chk("t4_read_span", last_rd - first_rd, 198);

        // reset in the middle of a 512-byte frame
        clear_counts();
        load_frame(1, {12'h0A5, 12'd512}, 8'h20);
        expect_frame(1, 512, 8'h20, 1);
        for (int i = 0; i < 700 && n_tx < 37; i++) @(negedge clk_sys);
        chk("t5_reached_byte37", n_tx, 37);
        @(posedge clk_sys);
        #1 reset = 1'b1;
        @(negedge clk_sys);
        #1 exp_byte.delete();
        @(posedge clk_sys);
        #1 hq.delete();
        hd.delete();
        @(negedge clk_sys);
        chk("t5_reset_outputs", outs(), 0);
        @(posedge clk_sys);
        #1 reset = 1'b0;
        load_frame(1, {12'h0A5, 12'd64}, 8'h30);
        expect_frame(1, 64, 8'h30, 1);
        wait_drain("t5_drain", 300);

        // zero-length ctrl word
        clear_counts();
        load_frame(0, {12'h0A5, 12'd0}, 8'h00);
        expect_frame(0, 0, 8'h00, 0);
        wait_drain("t6_drain", 100);
        chk("t6_discard_cycles", n_disc, 1);
        chk("t6_data_reads", n_hrd + n_lrd, 0);
        chk("t6_ctrl_pops", n_ctrl, 1);
        chk("t6_busy_cycles", n_busy, 1);

        chk("scoreboard_empty", exp_byte.size() + exp_grant.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
